// File: rtl/sram_controller.sv
// sram_controller
//   Sequences a 16-bit asynchronous SRAM as the 32-bit data memory of the
//   pipeline's MEM stage. Each word access is split into a low half-word
//   transaction followed by a high half-word transaction. Each half lasts
//   WAIT_CYCLES clocks. A one-cycle DONE state then releases the pipeline.
//
//   Optional build macro: SRAM_POSTED_WRITE_EN
//     When defined, a write accepted in IDLE does not stall the pipeline. It
//     completes in the background from the latched address and data.
//
// Ports
//   clk, rst      pipeline clock, synchronous active-high reset
//   wr_en, rd_en  store / load request (both high = store), held while ready=0
//   address       mapped byte address, bits [18:2] select the word
//   writeData     store value
//   readData      load result, holds until the next load overwrites it
//   ready         0 = freeze the pipeline
//   SRAM_*        SRAM pins (CE/OE/UB/LB tied active)
//   dbg_state     current FSM state (0 IDLE, 1 LOW, 2 HIGH, 3 DONE)
//
// Handshake: a request (rd_en|wr_en) is complete in the cycle where it sees
// ready=1. The pipeline keeps the request stable until then, and may present
// the next request in the very next cycle.
module sram_controller #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [16:0] lat_addr;
    logic [31:0] lat_data;
    logic        lat_write;
    logic [15:0] dq_out;
    logic        dq_oe;
`ifdef SRAM_POSTED_WRITE_EN
    logic        posted;   // the access in flight is a posted write
`endif

    // Address bits outside the 512 KiB SRAM window are not used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign dbg_state = state;

    // Outputs towards the SRAM are registered. They are loaded with the value
    // for the state being entered, so they line up exactly with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_addr  <= 17'd0;
            lat_data  <= 32'd0;
            lat_write <= 1'b0;
            readData  <= 32'd0;
            SRAM_ADDR <= 18'd0;
            SRAM_WE_N <= 1'b1;
            dq_out    <= 16'd0;
            dq_oe     <= 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
            posted    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en || wr_en) begin
                        state     <= LOW;
                        cnt       <= 4'd0;
                        lat_addr  <= address[18:2];
                        lat_data  <= writeData;
                        lat_write <= wr_en;
                        SRAM_ADDR <= {address[18:2], 1'b0};
                        SRAM_WE_N <= !wr_en;
                        dq_out    <= writeData[15:0];
                        dq_oe     <= wr_en;
`ifdef SRAM_POSTED_WRITE_EN
                        posted    <= wr_en;
`endif
                    end
                end
                LOW: begin
                    if (cnt == CNT_LAST) begin
                        state     <= HIGH;
                        cnt       <= 4'd0;
                        SRAM_ADDR <= {lat_addr, 1'b1};
                        dq_out    <= lat_data[31:16];
                        if (!lat_write) readData[15:0] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        cnt       <= 4'd0;
                        SRAM_ADDR <= 18'd0;
                        SRAM_WE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        if (!lat_write) readData[31:16] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
`ifdef SRAM_POSTED_WRITE_EN
                    posted <= 1'b0;
`endif
                end
            endcase
        end
    end

`ifdef SRAM_POSTED_WRITE_EN
    // A write arriving in IDLE completes at once. Anything arriving while the
    // engine is busy waits. The DONE of a posted write belongs to nobody, so
    // it must not release whatever request is currently waiting.
    always_comb begin
        ready = 1'b1;
        if (rd_en || wr_en) begin
            case (state)
                IDLE:    ready = wr_en;
                DONE:    ready = !posted;
                default: ready = 1'b0;
            endcase
        end
    end
`else
    always_comb begin
        ready = !((rd_en || wr_en) && (state != DONE));
    end
`endif

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
//   Randomized bench for sram_controller. It contains:
//   - an SRAM pin model,
//   - a word-level reference memory with a timing model,
//   - an expected queue of SRAM write cycles checked on the bus.
module tb_sram_controller;

    localparam int W = 2;
`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    localparam int ACCESS = 2 * W + 1;   // stall cycles of a full access

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, writeData;
    logic [31:0] readData;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;
    logic [1:0]  dbg_state;

    sram_controller #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .writeData(writeData), .readData(readData),
        .ready(ready), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM pin model ----------------
    logic [15:0] sram_mem [0:262143];
    assign SRAM_DQ = (SRAM_WE_N && !SRAM_OE_N) ? sram_mem[SRAM_ADDR] : 16'hzzzz;
    always @(posedge clk)
        if (!SRAM_WE_N && !SRAM_CE_N) sram_mem[SRAM_ADDR] <= SRAM_DQ;

    // ---------------- checker ----------------
    int n_cmp = 0;
    int n_err = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] last_read = 32'd0;
    int          idle_at = 0;        // first cycle the controller is idle again
    logic [33:0] exp_q[$];           // expected {SRAM_ADDR, SRAM_DQ} per write clock

    function automatic logic [31:0] ref_word(input logic [16:0] k);
        return ref_mem.exists(k) ? ref_mem[k] : 32'd0;
    endfunction

    // Every clock spent writing must match the next expected half-word.
    always @(negedge clk) begin
        if (!rst && SRAM_WE_N === 1'b0) begin
            check("bus_write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("bus_write", 64'({SRAM_ADDR, SRAM_DQ}), 64'(exp_q.pop_front()));
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after a rising edge with
    // the request removed, so the next call is back-to-back.
    task automatic access(input bit do_wr, input bit do_rd, input logic [31:0] addr,
                          input logic [31:0] data);
        logic [16:0] k;
        int pre, exp_stall, stalls;
        bit is_wr;
        logic [31:0] exp_rd;
        k      = addr[18:2];
        is_wr  = do_wr;
        pre    = (idle_at > cyc) ? idle_at - cyc : 0;
        exp_stall = (POSTED && is_wr) ? pre : pre + ACCESS;
        idle_at = cyc + pre + ACCESS + 1;
        exp_rd = ref_word(k);
        if (is_wr) begin
            ref_mem[k] = data;
            for (int i = 0; i < W; i++) exp_q.push_back({k, 1'b0, data[15:0]});
            for (int i = 0; i < W; i++) exp_q.push_back({k, 1'b1, data[31:16]});
        end
        wr_en = do_wr; rd_en = do_rd; address = addr; writeData = data;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            stalls++;
            if (stalls > 200) break;
            @(posedge clk); #1;
        end
        check(is_wr ? "write_stalls" : "read_stalls", 64'(stalls), 64'(exp_stall));
        if (is_wr) begin
            check("readData_kept", 64'(readData), 64'(last_read));
        end else begin
            check("readData", 64'(readData), 64'(exp_rd));
            last_read = exp_rd;
        end
        check("addr_idle_at_ready", 64'(SRAM_ADDR), 64'd0);
        check("we_n_at_ready", 64'(SRAM_WE_N), 64'd1);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < idle_at) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [16:0] pool [6];
    logic [31:0] a, d;
    int          op;

    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
        rst = 1'b1; rd_en = 1'b1; wr_en = 1'b0; address = 32'h10; writeData = 32'd0;

        // reset held for two cycles with a read pending
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_we_n", 64'(SRAM_WE_N), 64'd1);
        check("rst_readData", 64'(readData), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        check("post_rst_state", 64'(dbg_state), 64'd0);
        check("post_rst_addr", 64'(SRAM_ADDR), 64'd0);
        check("idle_ready", 64'(ready), 64'd1);
        @(posedge clk); #1;
        idle_at = cyc;

        // write then read, then back-to-back reads, issued with no gap
        access(1, 0, 32'h0000_0010, 32'hDEAD_BEEF);
        access(0, 1, 32'h0000_0010, 32'h0);
        access(1, 0, 32'h0000_0024, 32'h1234_5678);
        access(0, 1, 32'h0000_0024, 32'h0);
        access(0, 1, 32'h0000_0010, 32'h0);

        // both enables high acts as a write
        access(1, 1, 32'h0000_0100, 32'hCAFE_F00D);
        access(0, 1, 32'h0000_0100, 32'h0);

        // reset during the HIGH half of a read
        wait_idle();
        rd_en = 1'b1; address = 32'h0000_0010;
        repeat (W + 1) @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_in_high", 64'(dbg_state), 64'd2);
        rst = 1'b1; rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_state", 64'(dbg_state), 64'd0);
        check("midrst_readData", 64'(readData), 64'd0);
        last_read = 32'd0;
        @(posedge clk); #1;
        idle_at = cyc;
        access(0, 1, 32'h0000_0010, 32'h0);

        // randomized traffic over a small pool of words, random upper/lower bits
        for (int i = 0; i < 6; i++) pool[i] = 17'($urandom);
        for (int i = 0; i < 60; i++) begin
            a  = {13'($urandom), pool[$urandom_range(0, 5)], 2'($urandom)};
            d  = $urandom;
            op = $urandom_range(0, 3);
            case (op)
                0, 1: access(0, 1, a, d);
                2:    access(1, 0, a, d);
                default: access(1, 1, a, d);
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("bus_writes_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences the off-chip 16-bit SRAM serving as data memory for the 5-stage MIPS pipeline. It sits in the MEM stage and receives the mapped data-memory byte address, store value and read/write enables. Each 32-bit access is split into two 16-bit SRAM transactions. `ready` freezes the pipeline until the access completes.

## Interface
- `WAIT_CYCLES`, default 2: SRAM cycles spent per 16-bit half; legal range 1–15.
- `clk`  in  1: pipeline clock.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: store request; held stable by the pipeline while `ready`=0.
- `rd_en`  in  1: load request; held stable by the pipeline while `ready`=0.
- `address`  in  32: data-memory byte address, already mapped; bits [1:0] ignored.
- `writeData`  in  32: store value.
- `readData`  out  32: load result.
- `ready`  out  1: 0 = freeze the pipeline.
- `SRAM_DQ`  inout  16: SRAM data bus.
- `SRAM_ADDR`  out  18: SRAM half-word address.
- `SRAM_WE_N`  out  1: write strobe, active low.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each: tied 0.

## Operation
- States are IDLE, LOW, HIGH and DONE, with a 4-bit wait counter `cnt`.
- **IDLE**
  - If `rd_en|wr_en`, latch `address`, `writeData` and the operation, then go to LOW with `cnt`=0.
  - If both enables are high, the access is a write.
- **LOW and HIGH**
  - `cnt` increments each cycle.
  - When `cnt`=WAIT_CYCLES-1, move to the next state and clear `cnt`.
  - LOW is followed by HIGH; HIGH is followed by DONE.
- **DONE**
  - Lasts one cycle, then returns to IDLE unconditionally.
- **SRAM address**
  - `SRAM_ADDR` = {latched_addr[18:2], half}.
  - `half` is 0 in LOW and 1 in HIGH.
  - In IDLE and DONE, `SRAM_ADDR` = 0.
- **Writes**
  - In LOW and HIGH, `SRAM_WE_N`=0.
  - `SRAM_DQ` is driven with latched data [15:0] in LOW and [31:16] in HIGH.
  - Otherwise `SRAM_DQ` is high-Z and `SRAM_WE_N`=1.
- **Reads**
  - `SRAM_DQ` is sampled into `readData[15:0]` on the last LOW cycle and into `readData[31:16]` on the last HIGH cycle.
  - `readData` holds its value until the next read overwrites it; writes never change it.
- **ready** (combinational)
  - `ready` = !((rd_en|wr_en) && state != DONE).
  - With no request, `ready`=1.
- Input changes while the state is not IDLE are ignored; only latched values are used.

## Timing
- **Reset values:** state IDLE, `cnt`=0, `readData`=0, `SRAM_WE_N`=1, `SRAM_DQ` high-Z, `SRAM_ADDR`=0.
- **Access length:** a request presented in IDLE at cycle 0 completes in 2·WAIT_CYCLES+2 cycles.
  - `ready`=0 for cycles 0 … 2·WAIT_CYCLES.
  - `ready`=1 in DONE, at cycle 2·WAIT_CYCLES+1.
  - `readData` is valid in that DONE cycle.
  - Default WAIT_CYCLES=2 gives 5 stall cycles, with the result in cycle 5.
- **Back-to-back requests:** a request present in the cycle after DONE starts immediately from IDLE; there is no extra bubble.
- **Reset mid-access:** the state goes to IDLE on the next edge.
  - A partially written word is undefined in the SRAM.
  - `readData` = 0.

## Configuration
- `SRAM_POSTED_WRITE_EN`
  - **When defined**
    - A write accepted in IDLE does not stall: `ready` stays 1 that cycle, and the write runs in the background using the latched address and data.
    - While a posted write occupies LOW, HIGH or DONE, any new request sees `ready`=0.
    - That new request starts once the controller returns to IDLE.
    - The posted write's DONE cycle never raises `ready` for a different request.
    - Reads are unchanged.
  - **When undefined:** writes stall exactly like reads.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `rd_en`=1 → `SRAM_WE_N`=1, `readData`=0, and state is IDLE when `rst` is released.
- **Write then read:** write 0xDEADBEEF at 0x0000_0010, then read 0x0000_0010 (SRAM model) → `SRAM_ADDR` 0x00008 then 0x00009, with DQ 0xBEEF then 0xDEAD. `ready` is low for 5 cycles, and `readData`=0xDEADBEEF in DONE.
- **Back-to-back reads:** two reads of different addresses in consecutive DONE/IDLE cycles → second `ready`=0 begins on the cycle immediately after the first DONE, with no idle gap.
- **Simultaneous enables:** `rd_en`=`wr_en`=1 → treated as a write; `readData` is unchanged.
- **Mid-access reset:** assert `rst` during HIGH of a read → IDLE next cycle and `readData`=0; the next read completes normally.
- **Posted write (`SRAM_POSTED_WRITE_EN`):** a write followed by a read in the next cycle → `ready`=1 for the write, and `ready`=0 for the read until the write finishes. The read then takes the full 5 stall cycles and returns the newly written value.
